msi_arbiter: RTL and testbench

MSI_ARBITER -- requirements
Module: msi_arbiter

---
 rtl/msi_arbiter.sv | 172 +++++++++++++++++
 tb/tb_msi_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msi_arbiter.sv
// -----------------------------------------------------------------------------
// msi_arbiter
//
// Collects level interrupt flags from N_SRC peripherals, turns their rising
// edges into sticky pending bits and issues them one at a time as MSI requests
// to the PCIe core. Winners are picked round-robin among unmasked pending
// sources. Every granted request is followed by GAP_CYCLES forced idle cycles.
// Rises that land on a bit that is already pending are merged and counted.
//
// Handshake: msi_request rises together with a valid msi_vector and both stay
// constant until the core pulses msi_grant for one cycle. The request drops on
// the edge that samples msi_grant. msi_grant outside an outstanding request is
// ignored.
//
// Ports
//   axi_clk_pcie  in   sole clock, rising edge
//   sys_reset     in   asynchronous active-high reset
//   irq_level     in   [N_SRC] level interrupt flags (synchronous)
//   irq_mask      in   [N_SRC] 1 = source blocked from issue (still pends)
//   msi_enabled   in   host has MSI enabled; gates new requests only
//   msi_grant     in   single-cycle grant from the PCIe core
//   msi_request   out  MSI request to the PCIe core
//   msi_vector    out  [4] source index of the in-flight request
//   pending_o     out  [N_SRC] pending register
//   coalesce_cnt  out  [8] saturating count of merged rises
// -----------------------------------------------------------------------------
module msi_arbiter #(
  parameter int N_SRC      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic             axi_clk_pcie,
  input  logic             sys_reset,
  input  logic [N_SRC-1:0] irq_level,
  input  logic [N_SRC-1:0] irq_mask,
  input  logic             msi_enabled,
  input  logic             msi_grant,
  output logic             msi_request,
  output logic [3:0]       msi_vector,
  output logic [N_SRC-1:0] pending_o,
  output logic [7:0]       coalesce_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Gap counter load value; it counts down to zero, so GAP_CYCLES-1 gives
  // exactly GAP_CYCLES cycles in ST_GAP.
  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  state_t           state;
  logic [N_SRC-1:0] irq_prev;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] merge;
  logic [15:0]      elig16;
  logic [3:0]       last_winner;
  logic [3:0]       gap_cnt;
  logic [3:0]       win_idx;
  logic             win_valid;
  logic             issue;
  logic [4:0]       cand;
  logic [4:0]       coal_inc;
  logic [8:0]       coal_sum;

  assign rise      = irq_level & ~irq_prev;
  assign eligible  = pending & ~irq_mask;
  assign elig16    = 16'(eligible);
  assign pending_o = pending;

  // Round-robin search: walk indices last_winner+1 .. last_winner+N_SRC,
  // wrapping by a single conditional subtract, and keep the first eligible.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      cand = {1'b0, last_winner} + 5'(k);
      if (cand >= 5'(N_SRC)) cand = cand - 5'(N_SRC);
      if (!win_valid && elig16[cand[3:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[3:0];
      end
    end
  end

  assign issue = (state == ST_IDLE) && msi_enabled && win_valid;

  // One-hot clear of the issued source.
  always_comb begin
    clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      clr[i] = issue && (win_idx == 4'(i));
    end
  end

  // A rise merges only into a bit that stays pending this cycle; a rise on the
  // bit being issued re-arms it instead of counting.
  assign merge = rise & pending & ~clr;

  always_comb begin
    coal_inc = '0;
    for (int i = 0; i < N_SRC; i++) begin
      coal_inc = coal_inc + 5'(merge[i]);
    end
  end

  assign coal_sum = {1'b0, coalesce_cnt} + 9'(coal_inc);

  // Edge detection, pending bits and merge counter.
  always_ff @(posedge axi_clk_pcie or posedge sys_reset) begin
    if (sys_reset) begin
      irq_prev     <= '0;
      pending      <= '0;
      coalesce_cnt <= '0;
    end else begin
      irq_prev     <= irq_level;
      pending      <= (pending & ~clr) | rise;
      coalesce_cnt <= (coal_sum > 9'd255) ? 8'hFF : coal_sum[7:0];
    end
  end

  // Issue FSM with registered request/vector.
  always_ff @(posedge axi_clk_pcie or posedge sys_reset) begin
    if (sys_reset) begin
      state       <= ST_IDLE;
      msi_request <= 1'b0;
      msi_vector  <= '0;
      last_winner <= 4'(N_SRC - 1);
      gap_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue) begin
            state       <= ST_REQ;
            msi_request <= 1'b1;
            msi_vector  <= win_idx;
            last_winner <= win_idx;
          end
        end
        ST_REQ: begin
          // Held regardless of msi_enabled until the core grants.
          if (msi_grant) begin
            msi_request <= 1'b0;
            if (GAP_CYCLES == 0) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_GAP;
              gap_cnt <= GAP_LOAD;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == 4'd0) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          msi_request <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_msi_arbiter
//
// Directed bench for msi_arbiter (N_SRC=4, GAP_CYCLES=2). A behavioural model
// tracks pending bits, the round-robin pointer, the outstanding request and
// the remaining forced-idle count; it is compared against the DUT on every
// falling edge. Directed scenarios add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_msi_arbiter;

  localparam int N   = 4;
  localparam int GAP = 2;

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic [3:0] lvl   = '0;
  logic [3:0] mask  = '0;
  logic       en    = 1'b0;
  logic       grant = 1'b0;

  logic       msi_request;
  logic [3:0] msi_vector;
  logic [3:0] pending_o;
  logic [7:0] coalesce_cnt;

  always #5 clk = ~clk;

  msi_arbiter #(.N_SRC(N), .GAP_CYCLES(GAP)) dut (
    .axi_clk_pcie (clk),
    .sys_reset    (rst),
    .irq_level    (lvl),
    .irq_mask     (mask),
    .msi_enabled  (en),
    .msi_grant    (grant),
    .msi_request  (msi_request),
    .msi_vector   (msi_vector),
    .pending_o    (pending_o),
    .coalesce_cnt (coalesce_cnt)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0] m_prev = '0;
  logic [3:0] m_pend = '0;
  int         m_coal = 0;
  bit         m_req  = 1'b0;
  int         m_vec  = 0;
  int         m_last = N - 1;
  int         m_gap  = 0;   // forced idle edges still to elapse

  task automatic model_reset();
    m_prev = '0;
    m_pend = '0;
    m_coal = 0;
    m_req  = 1'b0;
    m_vec  = 0;
    m_last = N - 1;
    m_gap  = 0;
  endtask

  task automatic model_step();
    logic [3:0] rise;
    logic [3:0] taken;
    int idx;
    rise  = lvl & ~m_prev;
    taken = '0;
    if (m_req) begin
      if (grant) begin
        m_req = 1'b0;
        m_gap = GAP;
      end
    end else if (m_gap > 0) begin
      m_gap = m_gap - 1;
    end else if (en) begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (m_pend[idx] && !mask[idx]) begin
          m_req      = 1'b1;
          m_vec      = idx;
          m_last     = idx;
          taken[idx] = 1'b1;
          break;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (rise[i] && m_pend[i] && !taken[i]) m_coal = (m_coal < 255) ? m_coal + 1 : 255;
      m_pend[i] = (m_pend[i] && !taken[i]) || rise[i];
    end
    m_prev = lvl;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("mdl_request", 32'(msi_request), 32'(m_req));
      chk("mdl_vector", 32'(msi_vector), 32'(m_vec));
      chk("mdl_pending", 32'(pending_o), 32'(m_pend));
      chk("mdl_coalesce", 32'(coalesce_cnt), 32'(m_coal));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  // Waits (bounded) at falling edges for msi_request; reports low cycles seen.
  task automatic wait_req(input int budget, output int low_cycles, output bit ok);
    low_cycles = 0;
    ok         = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (msi_request) begin
        ok = 1'b1;
        break;
      end
      low_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic do_grant();
    grant = 1'b1;
    @(negedge clk);
    grant = 1'b0;
  endtask

  int fair_exp[3] = '{0, 1, 3};

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int low;
    bit ok;
    int cnt;

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_request", 32'(msi_request), 0);
    chk("rst_vector", 32'(msi_vector), 0);
    chk("rst_pending", 32'(pending_o), 0);
    chk("rst_coalesce", 32'(coalesce_cnt), 0);
    rst    = 1'b0;
    cmp_en = 1'b1;
    tick();
    tick();

    // Fairness: 0,1,3 rise together, issued in index order from reset.
    en  = 1'b1;
    lvl = 4'b1011;
    for (int r = 0; r < 3; r++) begin
      wait_req(12, low, ok);
      chk("fair_req_seen", 32'(ok), 1);
      chk("fair_vec", 32'(msi_vector), 32'(fair_exp[r]));
      // Low time between requests: GAP forced cycles plus the IDLE decision cycle.
      if (r == 0) chk("fair_latency", 32'(low), 2);
      else        chk("fair_gap", 32'(low), 32'(GAP + 1));
      do_grant();
    end
    chk("fair_pending_empty", 32'(pending_o), 0);
    lvl = '0;
    repeat (4) tick();

    // Single source 2.
    lvl = 4'b0100;
    tick();
    chk("single_pend", 32'(pending_o), 32'h4);
    chk("single_req_not_yet", 32'(msi_request), 0);
    tick();
    chk("single_req", 32'(msi_request), 1);
    chk("single_vec", 32'(msi_vector), 2);
    chk("single_pend_clr", 32'(pending_o), 0);
    do_grant();
    for (int c = 0; c < GAP + 1; c++) begin
      chk("single_idle", 32'(msi_request), 0);
      tick();
    end
    chk("single_pend_final", 32'(pending_o), 0);
    lvl = '0;
    repeat (2) tick();

    // Coalesce: source 1 rises while vector 0 waits, then three more rises.
    lvl = 4'b0001;
    wait_req(8, low, ok);
    chk("coal_req0_seen", 32'(ok), 1);
    chk("coal_vec0", 32'(msi_vector), 0);
    lvl = 4'b0011;
    tick();
    for (int t = 0; t < 3; t++) begin
      lvl = 4'b0001;
      tick();
      lvl = 4'b0011;
      tick();
    end
    chk("coal_cnt3", 32'(coalesce_cnt), 3);
    chk("coal_pend1", 32'(pending_o), 32'h2);
    chk("coal_hold_vec0", 32'(msi_vector), 0);
    do_grant();
    wait_req(10, low, ok);
    chk("coal_req1_seen", 32'(ok), 1);
    chk("coal_vec1", 32'(msi_vector), 1);
    do_grant();
    lvl = '0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (msi_request) cnt++;
      tick();
    end
    chk("coal_no_extra_msi", 32'(cnt), 0);

    // Gating and mask.
    en  = 1'b0;
    lvl = 4'b0001;
    repeat (3) tick();
    chk("gate_no_req", 32'(msi_request), 0);
    chk("gate_pend", 32'(pending_o), 32'h1);
    mask = 4'b0001;
    en   = 1'b1;
    repeat (3) tick();
    chk("mask_no_req", 32'(msi_request), 0);
    chk("mask_pend", 32'(pending_o), 32'h1);
    mask = 4'b0000;
    tick();
    chk("unmask_req", 32'(msi_request), 1);
    chk("unmask_vec", 32'(msi_vector), 0);
    do_grant();
    lvl = '0;
    repeat (4) tick();

    // Hold through msi_enabled drop, then reset mid-request.
    lvl = 4'b1000;
    wait_req(8, low, ok);
    chk("hold_req_seen", 32'(ok), 1);
    chk("hold_vec3", 32'(msi_vector), 3);
    en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("hold_req", 32'(msi_request), 1);
      chk("hold_vec", 32'(msi_vector), 3);
    end
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req", 32'(msi_request), 0);
    chk("async_rst_coal", 32'(coalesce_cnt), 0);
    chk("async_rst_pend", 32'(pending_o), 0);
    chk("async_rst_vec", 32'(msi_vector), 0);
    tick();
    tick();
    rst = 1'b0;
    // lvl[3] held high across release: exactly one rise.
    tick();
    chk("post_rst_pend", 32'(pending_o), 32'h8);
    chk("post_rst_coal", 32'(coalesce_cnt), 0);
    tick();
    chk("post_rst_single_rise", 32'(coalesce_cnt), 0);
    en = 1'b1;
    wait_req(6, low, ok);
    chk("post_rst_req_seen", 32'(ok), 1);
    chk("post_rst_vec3", 32'(msi_vector), 3);
    do_grant();
    lvl = '0;
    repeat (4) tick();

    // Simultaneous merges and saturation, all sources masked.
    mask = 4'hF;
    lvl  = 4'b0111;
    tick();
    tick();
    chk("sat_pend", 32'(pending_o), 32'h7);
    chk("sat_coal0", 32'(coalesce_cnt), 0);
    lvl = 4'b0000;
    tick();
    lvl = 4'b0111;
    tick();
    chk("multi_coal3", 32'(coalesce_cnt), 3);
    for (int t = 0; t < 300; t++) begin
      lvl = 4'b0110;
      tick();
      lvl = 4'b0111;
      tick();
    end
    chk("sat_coal255", 32'(coalesce_cnt), 255);
    chk("sat_no_req", 32'(msi_request), 0);

    // Drain everything.
    mask = 4'h0;
    for (int c = 0; c < 40; c++) begin
      grant = msi_request;
      tick();
    end
    grant = 1'b0;
    tick();
    chk("drain_pend", 32'(pending_o), 0);
    chk("drain_req", 32'(msi_request), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
